cpu_ctrl: RTL and testbench
===========================

CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: run  in  1  level; 1 = keep executing, 0 = stop at next instruction boundary.
REQ-004 SHALL have ports: imem_req out 1, imem_addr out 8, imem_ack in 1, imem_rdata in 16  instruction fetch handshake.
REQ-005 SHALL have ports: op  out  16  latched instruction word driven to the decoder.
REQ-006 SHALL have ports: dec_reg_we, dec_mem_we, dec_jmp, dec_load  in  1 each  decoder control outputs.
REQ-007 SHALL have ports: jmp_target  in  8  next-PC value from the datapath ALU.
REQ-008 SHALL have ports: dmem_req out 1, dmem_we out 1, dmem_ack in 1  data memory handshake.
REQ-009 SHALL have ports: reg_we out 1, zf_we out 1, pc out 8, halted out 1.

Function
REQ-010 FSM states SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-011 IDLE: go to FETCH when run=1; otherwise stay.
REQ-012 FETCH: imem_req=1 and imem_addr=pc held until a cycle with imem_ack=1. In that cycle, latch imem_rdata into op and go to DECODE. An ack in the first req cycle is valid.
REQ-013 imem_ack or dmem_ack while the matching req=0 SHALL be ignored.
REQ-014 DECODE: one cycle, no outputs pulsed; go to HALT if op[15:12] matches no opcode constant, else go to EXEC.
REQ-015 EXEC: zf_we=1 for one cycle iff opcode is CMP, CMPI or LTI. Go to MEM if dec_load or dec_mem_we, else go to WB.
REQ-016 MEM: dmem_req=1 and dmem_we=dec_mem_we held until dmem_ack=1; go to WB in the ack cycle.
REQ-017 WB: reg_we=dec_reg_we for exactly one cycle. pc <= dec_jmp ? jmp_target : pc+1, mod 256 (0xFF wraps to 0x00).
REQ-018 WB exit: go to FETCH if run=1, else IDLE. run=0 before WB SHALL NOT abort the current instruction.
REQ-019 HALT: halted=1, all request/strobe outputs 0, pc frozen; exit only via rst.
REQ-020 reg_we, zf_we and dmem_we SHALL never be 1 outside WB, EXEC and MEM respectively. At most one strobe SHALL be high per cycle.
REQ-021 Minimum latency with zero-wait acks: 4 cycles per non-memory instruction, 5 per LOAD/STORE.

Reset
REQ-022 On rst=1, asynchronously: state=IDLE, pc=0x00, op=0x0000, halted=0, and imem_req, dmem_req, dmem_we, reg_we, zf_we = 0.
REQ-023 rst asserted during FETCH or MEM SHALL drop the request in the same cycle. Any late ack after reset release SHALL be ignored per REQ-013.

Configuration
REQ-024 Macro CPU_CTRL_INSTRET_EN: when defined, add output instret (16 bits). It resets to 0, increments by 1 in each WB cycle, and wraps 0xFFFF to 0x0000.
REQ-025 Without CPU_CTRL_INSTRET_EN: no instret port and no counter logic; all other behaviour is identical.

Structure
REQ-026 Opcode constants (4-bit) and the FSM state enum SHALL live in the shared package cpu_pkg; cpu_ctrl SHALL NOT redefine them.
REQ-027 PC register and next-PC mux SHALL be a sub-module pc_unit (inputs: load enable, jmp select, jmp_target; output: pc). The FSM stays in cpu_ctrl.

Verification
REQ-028 Reset, run=1, imem returns ADD word with 0-wait ack -> imem_req high 1 cycle, reg_we pulse in cycle 4, pc 0x00->0x01.
REQ-029 CMPI fetched with 3-cycle ack delay -> imem_req held 3 cycles, zf_we pulse once in EXEC, reg_we stays 0.
REQ-030 LOAD with dmem_ack after 2 cycles -> dmem_req high 2 cycles, dmem_we=0, reg_we pulse in next cycle. STORE -> dmem_we=1 during MEM, reg_we=0.
REQ-031 JMP with jmp_target=0x40 at pc=0x10 -> pc=0x40 after WB; next imem_addr=0x40. Non-jump at pc=0xFF -> pc=0x00.
REQ-032 run dropped during MEM -> instruction completes, FSM enters IDLE, no further imem_req. Illegal opcode -> halted=1 and stays through run toggles until rst.
REQ-033 rst pulsed mid-MEM -> dmem_req 0 same cycle, pc=0x00. With CPU_CTRL_INSTRET_EN: 3 retired instructions -> instret=3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode constants, controller state encoding and opcode classification helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package cpu_pkg;

  // 4-bit opcode field op[15:12]; codes 0xC..0xF are unassigned and halt the core.
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_CMP   = 4'h6;
  localparam logic [3:0] OP_CMPI  = 4'h7;
  localparam logic [3:0] OP_LTI   = 4'h8;
  localparam logic [3:0] OP_LOAD  = 4'h9;
  localparam logic [3:0] OP_STORE = 4'hA;
  localparam logic [3:0] OP_JMP   = 4'hB;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  // True for every opcode the datapath implements.
  function automatic logic opcode_legal(input logic [3:0] opc);
    case (opc)
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
      OP_CMP, OP_CMPI, OP_LTI, OP_LOAD, OP_STORE, OP_JMP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Compare-class opcodes update the zero flag during EXEC.
  function automatic logic opcode_sets_zf(input logic [3:0] opc);
    return (opc == OP_CMP) || (opc == OP_CMPI) || (opc == OP_LTI);
  endfunction

endpackage

// File: rtl/cpu_ctrl_pc_unit.sv
// Program counter register with next-PC select (jump target or increment).
// Latency: pc updates on the clock edge ending a cycle with load=1.
// Backpressure: none; load is a single-cycle enable from the controller.
module pc_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       jmp,
  input  logic [7:0] jmp_target,
  output logic [7:0] pc
);

  // Advance to jump target or pc+1; the 8-bit add wraps 0xFF to 0x00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= 8'h00;
    end else if (load) begin
      pc <= jmp ? jmp_target : pc + 8'd1;
    end
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle CPU control FSM: fetch, decode, execute, memory, writeback, halt.
// Latency: 4 cycles per ALU/jump instruction, 5 per load/store with zero-wait acks.
// Backpressure: imem_req/dmem_req held until the matching ack; run=0 stops at the next WB.
// Optional build macro CPU_CTRL_INSTRET_EN adds a 16-bit retired-instruction counter port.
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] op,
  input  logic        dec_reg_we,
  input  logic        dec_mem_we,
  input  logic        dec_jmp,
  input  logic        dec_load,
  input  logic [7:0]  jmp_target,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        reg_we,
  output logic        zf_we,
  output logic [7:0]  pc,
  output logic        halted
`ifdef CPU_CTRL_INSTRET_EN
  ,
  output logic [15:0] instret
`endif
);

  state_t state;

  // Fetch address is always the architectural PC; imem_req qualifies it.
  assign imem_addr = pc;

  pc_unit u_pc (
    .clk        (clk),
    .rst        (rst),
    .load       (state == WB),
    .jmp        (dec_jmp),
    .jmp_target (jmp_target),
    .pc         (pc)
  );

  // Controller FSM; every output is registered on entry to the state that owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op       <= 16'h0000;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      reg_we   <= 1'b0;
      zf_we    <= 1'b0;
      halted   <= 1'b0;
    end else begin
      // Strobes live for exactly one cycle unless re-armed below.
      reg_we <= 1'b0;
      zf_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            op       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= DECODE;
          end
        end
        DECODE: begin
          if (!opcode_legal(op[15:12])) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state <= EXEC;
            zf_we <= opcode_sets_zf(op[15:12]);
          end
        end
        EXEC: begin
          if (dec_load || dec_mem_we) begin
            state    <= MEM;
            dmem_req <= 1'b1;
            dmem_we  <= dec_mem_we;
          end else begin
            state  <= WB;
            reg_we <= dec_reg_we;
          end
        end
        MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            state    <= WB;
            reg_we   <= dec_reg_we;
          end
        end
        WB: begin
          // run is only sampled here, so clearing it never aborts an instruction.
          if (run) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CPU_CTRL_INSTRET_EN
  // Retired-instruction counter: one count per WB cycle, wrapping at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= 16'h0000;
    end else if (state == WB) begin
      instret <= instret + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: table of instruction vectors plus reset/halt sequences.
// Latency: n/a.
// Backpressure: imem/dmem acks are modelled with per-vector wait counts.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] op;
  logic        dec_reg_we, dec_mem_we, dec_jmp, dec_load;
  logic [7:0]  jmp_target;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        reg_we, zf_we;
  logic [7:0]  pc;
  logic        halted;
`ifdef CPU_CTRL_INSTRET_EN
  logic [15:0] instret;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .op         (op),
    .dec_reg_we (dec_reg_we),
    .dec_mem_we (dec_mem_we),
    .dec_jmp    (dec_jmp),
    .dec_load   (dec_load),
    .jmp_target (jmp_target),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .reg_we     (reg_we),
    .zf_we      (zf_we),
    .pc         (pc),
    .halted     (halted)
`ifdef CPU_CTRL_INSTRET_EN
    ,
    .instret    (instret)
`endif
  );

  // One instruction: stimulus (word, decoder outputs, ack waits) and expected observations.
  // iw/dw = number of request cycles including the ack cycle. cap bounds the run.
  // lat = cycles from first fetch request to the cycle before the next fetch (or cap / halt).
  // rc/zc = cycle index (1-based from first fetch cycle) of the reg_we / zf_we pulse, 0 = none.
  typedef struct {
    logic [15:0] word;
    bit          rw, mw, jmp, ld;
    logic [7:0]  tgt;
    int          iw, dw;
    bit          drop;
    int          cap;
    int          lat, nim, ndm, nwe, nreg, nzf, rc, zc;
    logic [7:0]  pca;
    bit          halt;
  } vec_t;

  vec_t vec [12];

  function automatic vec_t mk(
    input logic [15:0] word, input bit rw, input bit mw, input bit jmp, input bit ld,
    input logic [7:0] tgt, input int iw, input int dw, input bit drop, input int cap,
    input int lat, input int nim, input int ndm, input int nwe, input int nreg,
    input int nzf, input int rc, input int zc, input logic [7:0] pca, input bit halt);
    vec_t v;
    v.word = word; v.rw = rw; v.mw = mw; v.jmp = jmp; v.ld = ld; v.tgt = tgt;
    v.iw = iw; v.dw = dw; v.drop = drop; v.cap = cap;
    v.lat = lat; v.nim = nim; v.ndm = ndm; v.nwe = nwe; v.nreg = nreg; v.nzf = nzf;
    v.rc = rc; v.zc = zc; v.pca = pca; v.halt = halt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one instruction through the controller, counting observed outputs per cycle.
  task automatic exec_instr(input string nm, input vec_t v);
    int  cyc, nim, ndm, nwe, nreg, nzf, rc, zc, coll;
    bit  fetched, done;
    nim = 0; ndm = 0; nwe = 0; nreg = 0; nzf = 0; rc = 0; zc = 0; coll = 0;
    run        = 1'b1;
    imem_rdata = v.word;
    dec_reg_we = v.rw;
    dec_mem_we = v.mw;
    dec_jmp    = v.jmp;
    dec_load   = v.ld;
    jmp_target = v.tgt;
    cyc = 0;
    while (!imem_req && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, " fetch_start"}, imem_req, 1);
    cyc = 0; fetched = 0; done = 0;
    while (!done) begin
      if (halted) done = 1;
      else if (fetched && imem_req) done = 1;
      else if (cyc >= v.cap) done = 1;
      else begin
        cyc++;
        if (imem_req) nim++;
        if (dmem_req) ndm++;
        if (dmem_we) nwe++;
        if (reg_we) begin nreg++; rc = cyc; end
        if (zf_we) begin nzf++; zc = cyc; end
        if (int'(reg_we) + int'(zf_we) + int'(dmem_we) > 1) coll++;
        if (dmem_we && !dmem_req) coll++;
        if (v.drop && dmem_req) run = 1'b0;
        imem_ack = imem_req && (nim == v.iw);
        dmem_ack = dmem_req && (ndm == v.dw);
        if (imem_ack) fetched = 1;
        @(negedge clk);
      end
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    chk({nm, " latency"}, cyc, v.lat);
    chk({nm, " imem_req_cycles"}, nim, v.nim);
    chk({nm, " dmem_req_cycles"}, ndm, v.ndm);
    chk({nm, " dmem_we_cycles"}, nwe, v.nwe);
    chk({nm, " reg_we_pulses"}, nreg, v.nreg);
    chk({nm, " zf_we_pulses"}, nzf, v.nzf);
    chk({nm, " reg_we_cycle"}, rc, v.rc);
    chk({nm, " zf_we_cycle"}, zc, v.zc);
    chk({nm, " strobe_overlap"}, coll, 0);
    chk({nm, " op_latched"}, op, v.word);
    chk({nm, " pc_after"}, pc, v.pca);
    chk({nm, " imem_addr"}, imem_addr, v.pca);
    chk({nm, " halted"}, halted, v.halt);
  endtask

  initial begin
    vec_t v;
    int   cnt;

    //               word     rw mw jp ld tgt    iw dw dr cap lat nim ndm nwe nrg nzf rc zc pc    halt
    vec[0]  = mk(16'h1123, 1, 0, 0, 0, 8'h00, 1, 0, 0, 40, 4,  1,  0,  0,  1,  0,  4, 0, 8'h01, 0); // ADD
    vec[1]  = mk(16'h7105, 0, 0, 0, 0, 8'h00, 3, 0, 0, 40, 6,  3,  0,  0,  0,  1,  0, 5, 8'h02, 0); // CMPI slow fetch
    vec[2]  = mk(16'h9210, 1, 0, 0, 1, 8'h00, 1, 2, 0, 40, 6,  1,  2,  0,  1,  0,  6, 0, 8'h03, 0); // LOAD
    vec[3]  = mk(16'hA210, 0, 1, 0, 0, 8'h00, 1, 1, 0, 40, 5,  1,  1,  1,  0,  0,  0, 0, 8'h04, 0); // STORE
    vec[4]  = mk(16'hB010, 0, 0, 1, 0, 8'h10, 1, 0, 0, 40, 4,  1,  0,  0,  0,  0,  0, 0, 8'h10, 0); // JMP 0x10
    vec[5]  = mk(16'hB040, 0, 0, 1, 0, 8'h40, 1, 0, 0, 40, 4,  1,  0,  0,  0,  0,  0, 0, 8'h40, 0); // JMP 0x40
    vec[6]  = mk(16'h6012, 0, 0, 0, 0, 8'h00, 2, 0, 0, 40, 5,  2,  0,  0,  0,  1,  0, 4, 8'h41, 0); // CMP
    vec[7]  = mk(16'hB0FF, 0, 0, 1, 0, 8'hFF, 1, 0, 0, 40, 4,  1,  0,  0,  0,  0,  0, 0, 8'hFF, 0); // JMP 0xFF
    vec[8]  = mk(16'h1456, 1, 0, 0, 0, 8'h33, 1, 0, 0, 40, 4,  1,  0,  0,  1,  0,  4, 0, 8'h00, 0); // ADD wrap
    vec[9]  = mk(16'h8301, 1, 0, 0, 0, 8'h00, 1, 0, 0, 40, 4,  1,  0,  0,  1,  1,  4, 3, 8'h01, 0); // LTI
    vec[10] = mk(16'h9320, 1, 0, 0, 1, 8'h00, 1, 3, 1, 12, 12, 1,  3,  0,  1,  0,  7, 0, 8'h02, 0); // LOAD, run drop
    vec[11] = mk(16'hC123, 1, 0, 0, 0, 8'h00, 1, 0, 0, 40, 2,  1,  0,  0,  0,  0,  0, 0, 8'h02, 1); // illegal

    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 16'h0000;
    dec_reg_we = 1'b0; dec_mem_we = 1'b0; dec_jmp = 1'b0; dec_load = 1'b0; jmp_target = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst imem_req", imem_req, 0);
    chk("rst dmem_req", dmem_req, 0);
    chk("rst dmem_we", dmem_we, 0);
    chk("rst reg_we", reg_we, 0);
    chk("rst zf_we", zf_we, 0);
    chk("rst pc", pc, 8'h00);
    chk("rst op", op, 16'h0000);
    chk("rst halted", halted, 0);
`ifdef CPU_CTRL_INSTRET_EN
    chk("rst instret", instret, 0);
`endif
    rst = 1'b0;

    // Stray acks while idle must be ignored.
    imem_ack = 1'b1; dmem_ack = 1'b1; imem_rdata = 16'hBEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("idle_stray_ack %0d", i), {imem_req, dmem_req, reg_we, op, pc},
          {1'b0, 1'b0, 1'b0, 16'h0000, 8'h00});
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;

    // Table-driven instruction vectors.
    for (int i = 0; i < 12; i++) begin
      exec_instr($sformatf("vec%0d", i), vec[i]);
    end

    // Halt persists through run toggles and stray acks.
    imem_ack = 1'b1; dmem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run = i[0];
      @(negedge clk);
      chk($sformatf("halt_hold %0d", i),
          {halted, imem_req, dmem_req, dmem_we, reg_we, zf_we, pc},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02});
    end
    imem_ack = 1'b0; dmem_ack = 1'b0; run = 1'b0;

    // Only reset leaves HALT.
    rst = 1'b1;
    #1;
    chk("halt_rst halted", halted, 0);
    chk("halt_rst pc", pc, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    exec_instr("post_halt_add", vec[0]);

    // Reset in the middle of a memory access.
    imem_rdata = 16'h9555; dec_load = 1'b1; dec_mem_we = 1'b0; dec_reg_we = 1'b1; dec_jmp = 1'b0;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    cnt = 0;
    while (!dmem_req && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("midmem dmem_req_seen", dmem_req, 1);
    chk("midmem pc_before", pc, 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("midmem dmem_req_drop", dmem_req, 0);
    chk("midmem pc_reset", pc, 8'h00);
    chk("midmem op_reset", op, 16'h0000);
    @(negedge clk);
    rst = 1'b0; run = 1'b0; dmem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("late_ack %0d", i), {dmem_req, dmem_we, imem_req, reg_we, pc},
          {1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    end
    dmem_ack = 1'b0;

    // Three retired instructions after reset.
    v = vec[0];
    for (int k = 1; k <= 3; k++) begin
      v.pca = k[7:0];
      exec_instr($sformatf("retire%0d", k), v);
    end
`ifdef CPU_CTRL_INSTRET_EN
    chk("instret_after_3", instret, 3);
`endif
    run = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
